// File: rtl/multicycle_pc_sequencer_if.sv
// Handshake and control bundle between the multi-cycle RV32I sequencer and its datapath/memories.
// The sequencer issues fetch/memory requests, so it takes the master side.
interface multicycle_pc_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             instr_valid;
    logic [6:0]       opcode;
    logic             branch_taken;
    logic [1:0]       target_lsb;
    logic             dmem_ready;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             ir_we;
    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic             rf_we;
    logic [2:0]       state;
    logic             trap;
    logic             halted;
    logic [CNT_W-1:0] retired;

    modport master (
        input  instr_valid, opcode, branch_taken, target_lsb, dmem_ready,
        output pc_we, pc_sel, ir_we, imem_req, dmem_req, dmem_we, rf_we,
        output state, trap, halted, retired
    );

    modport slave (
        output instr_valid, opcode, branch_taken, target_lsb, dmem_ready,
        input  pc_we, pc_sel, ir_we, imem_req, dmem_req, dmem_we, rf_we,
        input  state, trap, halted, retired
    );
endinterface

// File: rtl/multicycle_pc_sequencer.sv
// Control FSM of the multi-cycle RV32I core: sequences FETCH/DECODE/EXECUTE/MEM/WB,
// drives PC/IR/RF/DMEM strobes, counts retirements and traps on faults or timeouts.
module multicycle_pc_sequencer #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_pc_sequencer_if.master bus
);
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5,
        S_TRAP    = 3'd6,
        S_BAD     = 3'd7
    } state_e;

    state_e            state_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0]  retired_r;

    logic       pc_we_s;
    logic [1:0] pc_sel_s;
    logic       ir_we_s;
    logic       imem_req_s;
    logic       dmem_req_s;
    logic       dmem_we_s;
    logic       rf_we_s;
    logic       misaligned_s;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
            OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC, OP_SYSTEM: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

    assign misaligned_s = (bus.target_lsb != 2'b00);

    // Strobe decode from current state and same-cycle handshakes; held quiet during reset
    always_comb begin
        pc_we_s    = 1'b0;
        pc_sel_s   = 2'd0;
        ir_we_s    = 1'b0;
        imem_req_s = 1'b0;
        dmem_req_s = 1'b0;
        dmem_we_s  = 1'b0;
        rf_we_s    = 1'b0;
        if (rst) begin
            case (state_r)
                S_FETCH: begin
                    imem_req_s = 1'b1;
                    ir_we_s    = bus.instr_valid;
                end
                S_EXECUTE: begin
                    case (bus.opcode)
                        OP_BRANCH: begin
                            if (!bus.branch_taken) begin
                                pc_we_s = 1'b1;
                            end else if (!misaligned_s) begin
                                pc_we_s  = 1'b1;
                                pc_sel_s = 2'd1;
                            end else begin
                                pc_we_s = 1'b0;
                            end
                        end
                        OP_JAL, OP_JALR: begin
                            if (!misaligned_s) begin
                                pc_we_s  = 1'b1;
                                rf_we_s  = 1'b1;
                                pc_sel_s = (bus.opcode == OP_JAL) ? 2'd1 : 2'd2;
                            end else begin
                                pc_we_s = 1'b0;
                            end
                        end
                        default: pc_we_s = 1'b0;
                    endcase
                end
                S_MEM: begin
                    dmem_req_s = 1'b1;
                    dmem_we_s  = (bus.opcode == OP_STORE);
                    if (bus.dmem_ready && (bus.opcode == OP_STORE)) begin
                        pc_we_s = 1'b1;
                    end else begin
                        pc_we_s = 1'b0;
                    end
                end
                S_WB: begin
                    rf_we_s = 1'b1;
                    pc_we_s = 1'b1;
                end
                default: pc_we_s = 1'b0;
            endcase
        end else begin
            pc_we_s = 1'b0;
        end
    end

    // State, handshake wait counter and retirement counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= WAIT_W'(0);
            retired_r  <= CNT_W'(0);
        end else begin
            wait_cnt_r <= WAIT_W'(0);
            if (pc_we_s) begin
                retired_r <= retired_r + CNT_W'(1);
            end
            case (state_r)
                S_FETCH: begin
                    if (bus.instr_valid) begin
                        state_r <= S_DECODE;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        state_r <= S_TRAP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (!is_legal(bus.opcode)) begin
                        state_r <= S_TRAP;
                    end else if (bus.opcode == OP_SYSTEM) begin
                        state_r <= S_HALT;
                    end else begin
                        state_r <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    case (bus.opcode)
                        OP_BRANCH:                        state_r <= (bus.branch_taken && misaligned_s) ? S_TRAP : S_FETCH;
                        OP_JAL, OP_JALR:                  state_r <= misaligned_s ? S_TRAP : S_FETCH;
                        OP_LOAD, OP_STORE:                state_r <= S_MEM;
                        OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC: state_r <= S_WB;
                        default:                          state_r <= S_TRAP;
                    endcase
                end
                S_MEM: begin
                    // A response in the final allowed cycle still completes the access
                    if (bus.dmem_ready) begin
                        state_r <= (bus.opcode == OP_STORE) ? S_FETCH : S_WB;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        state_r <= S_TRAP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                S_WB:    state_r <= S_FETCH;
                S_HALT:  state_r <= S_HALT;
                S_TRAP:  state_r <= S_TRAP;
                default: state_r <= S_TRAP;
            endcase
        end
    end

    assign bus.pc_we    = pc_we_s;
    assign bus.pc_sel   = pc_sel_s;
    assign bus.ir_we    = ir_we_s;
    assign bus.imem_req = imem_req_s;
    assign bus.dmem_req = dmem_req_s;
    assign bus.dmem_we  = dmem_we_s;
    assign bus.rf_we    = rf_we_s;
    assign bus.state    = state_r;
    assign bus.trap     = (state_r == S_TRAP);
    assign bus.halted   = (state_r == S_HALT);
    assign bus.retired  = retired_r;
endmodule

// File: doc/multicycle_pc_sequencer.md
Name: multicycle_pc_sequencer

Overview:
Control FSM for the multi-cycle RV32I core. It sequences the program-counter register, instruction register, register-file write and data-memory handshake across FETCH/DECODE/EXECUTE/MEM/WB. It drives the PC write-enable and next-PC select consumed by the PC datapath, and counts retired instructions. It detects illegal opcodes, misaligned control-flow targets and memory timeouts, and enters a sticky trap state on any of them.

Parameters:
CNT_W, 32, width of retired-instruction counter
MEM_TIMEOUT, 16, max cycles waiting on instr_valid or dmem_ready before trap (must be >=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
instr_valid  input  1  instruction memory returned data this cycle
opcode  input  7  opcode field of instruction register
branch_taken  input  1  ALU branch comparison result, valid in EXECUTE
target_lsb  input  2  bits [1:0] of computed branch/jump target, valid in EXECUTE
dmem_ready  input  1  data memory completes access this cycle
pc_we  output  1  PC register write enable
pc_sel  output  2  next-PC select: 0=PC+4, 1=branch/JAL target, 2=JALR target
ir_we  output  1  instruction register load
imem_req  output  1  instruction fetch request
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write (store)
rf_we  output  1  register-file write enable
state  output  3  current state encoding
trap  output  1  sticky fault flag
halted  output  1  sticky halt flag (ECALL/EBREAK)
retired  output  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5, TRAP=6. Value 7 is unreachable; if entered, go to TRAP next cycle.
- rst low (async): state=FETCH, wait counter=0, retired=0, trap=0, halted=0. All strobes are 0 while rst is low.
- Outputs are a combinational decode of state plus handshake inputs. pc_sel=0 whenever pc_we=0.
- FETCH: imem_req=1.
  - instr_valid=1: ir_we=1, go to DECODE, clear wait counter.
  - Otherwise increment wait counter. When it reaches MEM_TIMEOUT, go to TRAP.
- DECODE: classify opcode.
  - Legal set: LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111, SYSTEM 1110011.
  - Any other opcode: go to TRAP.
  - SYSTEM: go to HALT.
  - All other legal opcodes: go to EXECUTE.
- EXECUTE:
  - BRANCH, not taken: pc_we=1, pc_sel=0, retired+1, go to FETCH.
  - BRANCH, taken: if target_lsb!=0, pc_we=0 and go to TRAP. Otherwise pc_we=1, pc_sel=1, retired+1, go to FETCH.
  - JAL/JALR: same misalignment check. If aligned: rf_we=1, pc_we=1, pc_sel=1 (JAL) or 2 (JALR), retired+1, go to FETCH.
  - LOAD/STORE: go to MEM, clear wait counter.
  - OP/OP-IMM/LUI/AUIPC: go to WB.
- MEM: dmem_req=1; dmem_we=1 for STORE.
  - dmem_ready=1 and STORE: pc_we=1, pc_sel=0, retired+1, go to FETCH.
  - dmem_ready=1 and LOAD: go to WB.
  - Otherwise the wait counter runs; reaching MEM_TIMEOUT goes to TRAP.
- WB: rf_we=1, pc_we=1, pc_sel=0, retired+1, go to FETCH.
- HALT: halted=1. TRAP: trap=1. Both are absorbing until rst; all strobes are 0 in both.
- Latency: ALU instruction takes 4 cycles with zero-wait memory (F,D,E,WB); store 4; load 5; branch/jump 3.
- Each instruction retires exactly once, in the cycle pc_we=1.
- instr_valid/dmem_ready arriving in a state that is not waiting for them are ignored.
- A handshake arriving in the same cycle the counter would hit MEM_TIMEOUT wins; no trap.
- rst asserted mid-instruction aborts immediately with no partial pc_we.

Test Plan:
- Reset, then 3 OP instructions with instr_valid every FETCH cycle -> pc_we pulses at cycles 4, 8, 12 with pc_sel=0; retired=3.
- BRANCH, branch_taken=1, target_lsb=0 -> pc_we=1, pc_sel=1 in EXECUTE (cycle 3); taken with target_lsb=2'b10 -> TRAP, pc_we never asserted, trap=1 sticky.
- LOAD with dmem_ready delayed 5 cycles -> MEM held 6 cycles with dmem_req=1, dmem_we=0, then WB with rf_we=1; total 10 cycles.
- FETCH with instr_valid held low, MEM_TIMEOUT=16 -> TRAP entered after 16 cycles; instr_valid on the 16th cycle -> DECODE, no trap.
- Illegal opcode 7'b1111111 -> TRAP after DECODE. Opcode 1110011 -> HALT, halted=1; further instr_valid ignored; retired unchanged.
- rst pulsed low mid-MEM -> all outputs 0 immediately, retired=0; after release, FETCH with imem_req=1.
